// File: rtl/cpu_sequencer.sv
// VeriRISC instruction-cycle controller: single-clock Moore FSM stepping 8 phases per instruction.
// Optional macro SEQ_SINGLE_STEP_EN adds a step input that gates each instruction at INST_ADDR.
module cpu_sequencer #(
   parameter int NPHASE      = 8,
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic       zero,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic [2:0] phase,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       load_ir,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_ac,
   output logic       data_e,
   output logic       fetch,
   output logic       halt,
   output logic [3:0] state_dbg
);

   if (NPHASE != 8) begin : g_nphase_check
      $error("cpu_sequencer: NPHASE must be 8");
   end

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8
   } state_t;

   state_t state, state_nxt;
   logic   alu_op;

   assign alu_op    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= INST_ADDR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
`ifdef SEQ_SINGLE_STEP_EN
         INST_ADDR:  state_nxt = step ? INST_FETCH : INST_ADDR;
`else
         INST_ADDR:  state_nxt = INST_FETCH;
`endif
         INST_FETCH: state_nxt = INST_LOAD;
         INST_LOAD:  state_nxt = IDLE;
         IDLE:       state_nxt = OP_ADDR;
         // HLT only freezes the sequence in the sticky variant; otherwise it just pulses halt
         OP_ADDR:    state_nxt = (HALT_STICKY && (opcode == OP_HLT)) ? HALTED : OP_FETCH;
         OP_FETCH:   state_nxt = ALU_OP;
         ALU_OP:     state_nxt = STORE;
         STORE:      state_nxt = INST_ADDR;
         HALTED:     state_nxt = HALTED;
         default:    state_nxt = INST_ADDR;
      endcase
   end

   always_comb begin
      phase   = state[2:0];
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      load_ir = 1'b0;
      inc_pc  = 1'b0;
      load_pc = 1'b0;
      load_ac = 1'b0;
      data_e  = 1'b0;
      fetch   = 1'b0;
      halt    = 1'b0;
      case (state)
         INST_ADDR: fetch = 1'b1;
         INST_FETCH: begin
            mem_rd = 1'b1;
            fetch  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            mem_rd  = 1'b1;
            load_ir = 1'b1;
            fetch   = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (opcode == OP_HLT);
         end
         OP_FETCH: mem_rd = alu_op;
         ALU_OP: begin
            mem_rd  = alu_op;
            inc_pc  = (opcode == OP_SKZ) && zero;
            load_pc = (opcode == OP_JMP);
            data_e  = (opcode == OP_STO);
         end
         STORE: begin
            mem_rd  = alu_op;
            load_ac = alu_op;
            inc_pc  = (opcode == OP_JMP);
            load_pc = (opcode == OP_JMP);
            mem_wr  = (opcode == OP_STO);
            data_e  = (opcode == OP_STO);
         end
         HALTED: begin
            // Frozen display of the phase that issued HLT
            phase = 3'd4;
            halt  = 1'b1;
         end
         default: begin
            phase = 3'd0;
            fetch = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Instruction-cycle controller for the VeriRISC datapath (program counter, instruction register, accumulator, ALU, shared 32x8 memory).
- Steps an 8-phase fetch/execute sequence, one phase per clk.
- Decodes the 3-bit opcode into the datapath strobes: memory read/write, IR/AC/PC loads, PC increment and data-bus drive.
- Replaces the externally divided cntrl_clk/fetch/alu_clk scheme with a single-clock Moore FSM.

Parameters:
- NPHASE, 8, number of phases per instruction. Fixed at 8; any other value is a compile-time error.
- HALT_STICKY, 1, 1 = halt is held until reset; 0 = halt is asserted only during the OP_ADDR phase of an HLT instruction.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  3  IR opcode field: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  input  1  accumulator-is-zero flag.
- phase  output  3  current phase index, 0..7.
- mem_rd  output  1  memory read enable.
- mem_wr  output  1  memory write strobe.
- load_ir  output  1  instruction register load.
- inc_pc  output  1  program counter increment.
- load_pc  output  1  program counter load from IR address field.
- load_ac  output  1  accumulator load from ALU output.
- data_e  output  1  drive accumulator onto the data bus.
- fetch  output  1  1 during phases 0-3: memory address mux selects PC; otherwise IR address.
- halt  output  1  CPU halted.

Behaviour:
- States, in order: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR.
- The state advances on each rising clk unless halted.
- All outputs are Moore: decoded from the state register and the opcode/zero inputs. No combinational path from opcode to state.
- ALUOP = opcode is ADD, AND, XOR or LDA.
- Output decode per state (every output not listed is 0):
  - INST_ADDR: all 0, fetch=1.
  - INST_FETCH: mem_rd=1, fetch=1.
  - INST_LOAD: mem_rd=1, load_ir=1, fetch=1.
  - IDLE: mem_rd=1, load_ir=1, fetch=1.
  - OP_ADDR: inc_pc=1; halt=1 if opcode=HLT.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP; inc_pc=(opcode=SKZ & zero); load_pc=(opcode=JMP); data_e=(opcode=STO).
  - STORE: mem_rd=ALUOP; load_ac=ALUOP; inc_pc=(opcode=JMP); load_pc=(opcode=JMP); mem_wr=(opcode=STO); data_e=(opcode=STO).
- mem_wr is never asserted in the same cycle as mem_rd.
- Halt with HALT_STICKY=1:
  - On the clk edge leaving OP_ADDR with opcode=HLT, the FSM enters HALTED.
  - In HALTED: halt=1, all strobes 0, phase=4, fetch=0. The FSM stays there until reset.
- Halt with HALT_STICKY=0: halt is a one-cycle pulse in OP_ADDR and the sequence continues.
- Reset (asserted low, at any time, including mid-instruction):
  - State goes to INST_ADDR immediately and asynchronously.
  - Outputs: phase=0, fetch=1, halt=0, all strobes 0.
  - The first state advance occurs on the first rising clk after reset deasserts.
- Latency:
  - Instruction length is 8 clks.
  - The IR is valid from phase 3.
  - Opcode must be stable from phase 3 through phase 7; opcode changes during phases 0-2 have no effect on the strobes.
- SKZ: PC is incremented twice (phases 4 and 6) when zero=1, which skips the next instruction.
- phase wraps from 7 to 0 with no idle gap.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - The FSM holds in INST_ADDR until a cycle with step=1, then proceeds through one full instruction and returns to INST_ADDR.
  - step is sampled only in INST_ADDR.
  - step=1 held continuously gives free-running behaviour.
- When undefined: no step port, and INST_ADDR always advances.

Test Plan:
- Reset low for 2 clks, then high -> during reset phase=0, fetch=1, all strobes 0; after release, phase counts 0,1,...,7,0 on successive clks.
- opcode=LDA (5), zero=0 -> mem_rd high in phases 1,2,3,5,6,7; load_ir in phases 2-3; inc_pc only in phase 4; load_ac only in phase 7; mem_wr never asserted.
- opcode=STO (6) -> data_e in phases 6-7; mem_wr only in phase 7; mem_rd low in phases 4-7; load_ac never asserted.
- opcode=SKZ (1) with zero=1 -> inc_pc in phases 4 and 6 (2 pulses per instruction); with zero=0 -> inc_pc in phase 4 only.
- opcode=JMP (7) -> load_pc in phases 6-7; inc_pc in phases 4 and 7.
- opcode=HLT (0), HALT_STICKY=1 -> halt rises in phase 4 and stays 1; phase frozen at 4 for 20 clks; reset low clears halt=0 and sets phase=0.
- Reset pulse asserted in phase 6 of an ADD -> asynchronous return to phase 0 with load_ac never pulsed.
